// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: size encodings, FSM states, latched request.
// byte_en() maps an access size and byte offset onto the 4 little-endian lanes of a word.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef struct packed {
        logic        we;
        size_t       size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [3:0] byte_en(input size_t size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: byte_en = 4'b0001 << lo;
            SZ_HALF: byte_en = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store data shift + byte enables, load lane extract + extension.
// Zero latency; no flow control of its own.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  size_t       size,
    input  logic [1:0]  addr_lo,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wdata_sh,
    output logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        misaligned
);

    logic [31:0] rsh;

    always_comb begin
        be         = byte_en(size, addr_lo);
        wdata_sh   = wdata << {addr_lo, 3'b000};
        rsh        = rword >> {addr_lo, 3'b000};
        misaligned = ((size == SZ_HALF) && addr_lo[0]) ||
                     ((size == SZ_WORD) && (addr_lo != 2'b00));
        case (size)
            SZ_BYTE: rdata = {{24{~uns & rsh[7]}}, rsh[7:0]};
            SZ_HALF: rdata = {{16{~uns & rsh[15]}}, rsh[15:0]};
            default: rdata = rword;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store memory responder: response 1+WAIT_CYCLES cycles after acceptance, held until rsp_ready.
// DMEM_PIPELINED_ACCEPT_EN lets a new request be accepted in the same cycle the response retires.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_CYCLES = 1,
    parameter string INIT_FILE   = "dmem.hex"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || DEPTH_WORDS < 1 || INIT_FILE == "") begin : g_bad_cfg
        $error("dmem_responder: unsupported parameter set");
    end

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, inc, cur;
    logic        accept, exec;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic        oor, mis, err;
    logic [31:0] wsh, ld;
    logic [3:0]  be;

    assign rsp_valid = (state_q == RESP);
    assign inc = '{we: req_we, size: size_t'(req_size), uns: req_unsigned,
                   addr: req_addr, wdata: req_wdata};

    // With zero wait the access executes on the accepting edge, so use the live request.
    assign cur  = accept ? inc : req_q;
    assign widx = cur.addr[AW+1:2];
    assign oor  = {2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS);
    assign err  = oor | mis | (cur.size == SZ_ILL);

    dmem_lane_align u_align (
        .size      (cur.size),
        .addr_lo   (cur.addr[1:0]),
        .uns       (cur.uns),
        .wdata     (cur.wdata),
        .rword     (mem[widx]),
        .wdata_sh  (wsh),
        .be        (be),
        .rdata     (ld),
        .misaligned(mis)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        accept    = 1'b0;
        exec      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    exec    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
`ifdef DMEM_PIPELINED_ACCEPT_EN
                req_ready = rsp_ready;
`endif
                if (rsp_ready) begin
                    state_d = IDLE;
`ifdef DMEM_PIPELINED_ACCEPT_EN
                    accept = req_valid;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (WAIT_CYCLES == 0) begin
                exec    = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d   = 4'(WAIT_CYCLES - 1);
                state_d = WAIT;
            end
        end
        if (reset) begin
            req_ready = 1'b0;
            accept    = 1'b0;
            exec      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            req_q     <= '0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q <= inc;
            end
            if (exec) begin
                rsp_err   <= err;
                rsp_rdata <= (err || cur.we) ? 32'd0 : ld;
            end
        end
    end

    // Storage is not reset; exec is already suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (exec && cur.we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[widx][8*b +: 8] <= wsh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores, error cases, stall and mid-wait reset.
module tb_dmem_responder;

    localparam int W = 1;
`ifdef DMEM_PIPELINED_ACCEPT_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W), .INIT_FILE("dmem.hex")) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   in_rsp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: latency, response contents and req_ready while a response is pending.
    always @(negedge clk) begin
        if (reset) begin
            acc_q.delete();
            in_rsp = 1'b0;
        end else begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    if (!in_rsp) begin
                        if (acc_q.size() > 0) check("latency", cyc - acc_q.pop_front(), 1 + W);
                        else fail_now("rsp_without_accept");
                        in_rsp = 1'b1;
                    end
                    check("rdata", rsp_rdata, exp_q[0].rdata);
                    check("err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
                    check("req_ready_in_resp", {31'd0, req_ready}, PIPE ? {31'd0, rsp_ready} : 32'd0);
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        in_rsp = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_now("accept_timeout");
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now("response_timeout");
            exp_q.delete();
        end
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee);
        exp_q.push_back('{er, ee});
        @(posedge clk);
        #1 drive(we, sz, uns, addr, wd);
        wait_accept();
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);

        // we, size, uns, addr, wdata, expected rdata, expected err
        xact(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
        xact(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
        xact(0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0);
        xact(0, 2'b00, 1, 32'h13,  32'h0,        32'h000000DE, 0);
        xact(0, 2'b01, 0, 32'h12,  32'h0,        32'hFFFFDEAD, 0);
        xact(0, 2'b01, 1, 32'h12,  32'h0,        32'h0000DEAD, 0);
        xact(1, 2'b00, 0, 32'h11,  32'hFFFFFF55, 32'h0,        0);
        xact(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEAD55EF, 0);
        xact(0, 2'b01, 0, 32'h11,  32'h0,        32'h0,        1);
        xact(0, 2'b10, 0, 32'h400, 32'h0,        32'h0,        1);
        xact(1, 2'b10, 0, 32'h0,   32'h12345678, 32'h0,        0);
        xact(1, 2'b10, 0, 32'h400, 32'hFFFFFFFF, 32'h0,        1);
        xact(1, 2'b10, 0, 32'h12,  32'hFFFFFFFF, 32'h0,        1);
        xact(1, 2'b11, 0, 32'h10,  32'hFFFFFFFF, 32'h0,        1);
        xact(0, 2'b11, 0, 32'h10,  32'h0,        32'h0,        1);
        xact(0, 2'b10, 0, 32'h0,   32'h0,        32'h12345678, 0);
        xact(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEAD55EF, 0);
        xact(0, 2'b00, 0, 32'h10,  32'h0,        32'hFFFFFFEF, 0);
        xact(0, 2'b01, 0, 32'h10,  32'h0,        32'h000055EF, 0);
        xact(0, 2'b00, 0, 32'h11,  32'h0,        32'h00000055, 0);
        xact(1, 2'b01, 0, 32'h12,  32'h00008001, 32'h0,        0);
        xact(0, 2'b10, 0, 32'h10,  32'h0,        32'h800155EF, 0);
        xact(0, 2'b01, 0, 32'h12,  32'h0,        32'hFFFF8001, 0);
        xact(0, 2'b10, 1, 32'h10,  32'h0,        32'h800155EF, 0);

        // Stall the response, then raise rsp_ready together with a new request.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        exp_q.push_back('{32'h800155EF, 1'b0});
        drive(0, 2'b10, 0, 32'h10, 32'h0);
        wait_accept();
        repeat (1 + W + 5) @(negedge clk);
        check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk);
        #1;
        exp_q.push_back('{32'h12345678, 1'b0});
        drive(0, 2'b10, 0, 32'h0, 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("handoff_req_ready", {31'd0, req_ready}, PIPE ? 32'd1 : 32'd0);
        if (req_ready) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
        end else begin
            wait_accept();
        end
        drain();

        // Reset while a store sits in WAIT: no write and no response.
        xact(1, 2'b10, 0, 32'h20, 32'hCAFEF00D, 32'h0, 0);
        @(posedge clk);
        #1 drive(1, 2'b10, 0, 32'h20, 32'h11111111);
        @(negedge clk);
        check("pre_reset_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_req_ready", {31'd0, req_ready}, 32'd0);
        check("mid_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        xact(0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFEF00D, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
